// File: rtl/fpa_ctrl_pkg.sv
// Shared types and helpers for the FP32 adder sharing controller.
package fpa_ctrl_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } fpa_state_e;

  // Pointer to the slot after the one just served; the last slot wraps to 0.
  function automatic int rr_next(input int idx, input int num_req);
    return (idx >= num_req - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fpa_add.sv
// Combinational FP32 adder: truncating alignment, zero exponent treated as
// zero, all-ones exponent on either input or overflow raises of with sum=0.
module fpa_add
  import fpa_ctrl_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] sum,
  output logic              cout,
  output logic              of
);

  logic [7:0]  ea, eb, el, es, diff;
  logic [23:0] ma, mb, ml, ms, ms_sh, sub_r;
  logic        sl, ss;
  logic [24:0] add_r;
  logic [22:0] norm;
  logic [8:0]  exp_r;
  int          lz;

  always_comb begin
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    if ({ea, ma} >= {eb, mb}) begin
      el = ea; ml = ma; sl = a[31];
      es = eb; ms = mb; ss = b[31];
    end else begin
      el = eb; ml = mb; sl = b[31];
      es = ea; ms = ma; ss = a[31];
    end
    diff  = el - es;
    ms_sh = (diff > 8'd23) ? 24'd0 : (ms >> diff);
    add_r = {1'b0, ml} + {1'b0, ms_sh};
    sub_r = ml - ms_sh;
    sum   = '0;
    cout  = 1'b0;
    of    = 1'b0;
    norm  = '0;
    exp_r = '0;
    lz    = 0;
    if (ea == 8'hFF || eb == 8'hFF) begin
      of = 1'b1;
    end else if (ml == 24'd0) begin
      sum = '0;
    end else if (sl == ss) begin
      cout = add_r[24];
      if (add_r[24]) begin
        exp_r = {1'b0, el} + 9'd1;
        norm  = add_r[23:1];
      end else begin
        exp_r = {1'b0, el};
        norm  = add_r[22:0];
      end
      if (exp_r >= 9'd255) of = 1'b1;
      else                 sum = {sl, exp_r[7:0], norm};
    end else if (sub_r != 24'd0) begin
      for (int i = 0; i < 24; i++) if (sub_r[i]) lz = 23 - i;
      norm = 23'(sub_r << lz);
      // Results that would need a denormal are flushed to zero.
      if (int'(el) > lz) sum = {sl, 8'(int'(el) - lz), norm};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// above ptr, wrapping to the lowest set request when none is found.
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] upper_req;
  logic [NUM_REQ-1:0] pick;

  always_comb begin
    upper_mask = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
    upper_req  = req & upper_mask;
    pick       = (upper_req != '0) ? upper_req : req;
    // Isolate the lowest set bit of the chosen request set.
    grant      = pick & (~pick + NUM_REQ'(1));
  end

endmodule

// File: rtl/fpa_share_ctrl.sv
// Round-robin sharing of one FP32 adder between NUM_REQ requesters.
// Define FPA_CTRL_STATS_EN to add the stat_ops/stat_of response counters.
module fpa_share_ctrl
  import fpa_ctrl_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [FP32_W*NUM_REQ-1:0] req_a,
  input  logic [FP32_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [FP32_W-1:0]         rsp_sum,
  output logic                      rsp_cout,
  output logic                      rsp_of
`ifdef FPA_CTRL_STATS_EN
  ,
  output logic [31:0]               stat_ops,
  output logic [31:0]               stat_of
`endif
);

  // Handshakes: a beat moves on the rising edge where valid & ready are both
  // high. req_ready may depend on req_valid; rsp_valid never depends on rsp_ready.
  fpa_state_e         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [FP32_W-1:0]  op_a, op_b;
  logic [ID_W-1:0]    op_id;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic [FP32_W-1:0]  gnt_a, gnt_b;
  logic               xfer;
  logic [FP32_W-1:0]  fpa_sum;
  logic               fpa_cout, fpa_of;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign xfer      = (req_valid & req_ready) != '0;

  always_comb begin
    gnt_idx = '0;
    gnt_a   = '0;
    gnt_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = ID_W'(i);
        gnt_a   = req_a[i*FP32_W +: FP32_W];
        gnt_b   = req_b[i*FP32_W +: FP32_W];
      end
    end
  end

  fpa_add u_fpa (
    .a    (op_a),
    .b    (op_b),
    .sum  (fpa_sum),
    .cout (fpa_cout),
    .of   (fpa_of)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_of    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            op_a   <= gnt_a;
            op_b   <= gnt_b;
            op_id  <= gnt_idx;
            rr_ptr <= ID_W'(rr_next(int'(gnt_idx), NUM_REQ));
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_sum   <= fpa_sum;
          rsp_cout  <= fpa_cout;
          rsp_of    <= fpa_of;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPA_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops <= '0;
      stat_of  <= '0;
    end else if (rsp_valid && rsp_ready) begin
      stat_ops <= stat_ops + 32'd1;
      if (rsp_of) stat_of <= stat_of + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpa_share_ctrl.sv
// Bench for fpa_share_ctrl: directed operations, expected responses queued at
// issue time and checked by an independent response monitor.
`timescale 1ns/1ps
module tb_fpa_share_ctrl;
  import fpa_ctrl_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 34;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [32*NUM_REQ-1:0] req_a = '0;
  logic [32*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          rsp_sum;
  logic                 rsp_cout, rsp_of;
`ifdef FPA_CTRL_STATS_EN
  logic [31:0]          stat_ops, stat_of;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int errors = 0;
  int checks = 0;

  fpa_share_ctrl #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_of    (rsp_of)
`ifdef FPA_CTRL_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_of   (stat_of)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [31:0] sum,
                          input logic cout, input logic of);
    exp_q.push_back({id, sum, cout, of});
  endtask

  // Waits for the next request transfer, returns the granted index just after
  // the transfer edge.
  task automatic wait_xfer(output int idx);
    idx = -1;
    for (int n = 0; n < 64 && idx < 0; n++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) begin
        check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
        for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_ready[i]) idx = i;
      end
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: no grant within 64 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, 0 required", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: id=%0d sum=0x%08h, no response required", rsp_id, rsp_sum);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp", 64'({rsp_id, rsp_sum, rsp_cout, rsp_of}), 64'(mon_e));
      end
    end
  end

  initial begin
    int g;
    // Reset state, with every requester asserting valid
    rst = 1'b1;
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'({rsp_id, rsp_sum, rsp_cout, rsp_of}), 64'd0);
    check("reset_state", 64'(dut.state), 64'd0);
    check("reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // All four requesters held valid: grant order 0,1,2,3,0
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h3F800000, 32'h3F800000);
    set_op(2, 32'h3F800000, 32'hBF800000);
    set_op(3, 32'h40000000, 32'h40000000);
    push_exp(2'd0, 32'h40400000, 1'b0, 1'b0);
    push_exp(2'd1, 32'h40000000, 1'b1, 1'b0);
    push_exp(2'd2, 32'h00000000, 1'b0, 1'b0);
    push_exp(2'd3, 32'h40800000, 1'b1, 1'b0);
    push_exp(2'd0, 32'h40400000, 1'b0, 1'b0);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_xfer(g);
      check("rr_order", 64'(g), 64'(k % NUM_REQ));
    end
    req_valid = '0;
    wait_drain();

    // Single requester 1.0 + 2.0 and its latency
    set_op(0, 32'h3F800000, 32'h40000000);
    push_exp(2'd0, 32'h40400000, 1'b0, 1'b0);
    req_valid[0] = 1'b1;
    wait_xfer(g);
    req_valid[0] = 1'b0;
    check("single_grant", 64'(g), 64'd0);
    check("single_calc_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    check("single_resp_valid", 64'(rsp_valid), 64'd1);
    wait_drain();

    // Special exponent input
    set_op(2, 32'h7F800000, 32'h3F800000);
    push_exp(2'd2, 32'h00000000, 1'b0, 1'b1);
    req_valid[2] = 1'b1;
    wait_xfer(g);
    req_valid[2] = 1'b0;
    check("special_grant", 64'(g), 64'd2);
    wait_drain();

    // Exponent overflow on carry-out
    set_op(3, 32'h7F000000, 32'h7F000000);
    push_exp(2'd3, 32'h00000000, 1'b1, 1'b1);
    req_valid[3] = 1'b1;
    wait_xfer(g);
    req_valid[3] = 1'b0;
    wait_drain();

    // Backpressure: response held for 10 cycles while req1 waits
    rsp_ready = 1'b0;
    set_op(1, 32'h3F800000, 32'h3F000000);
    push_exp(2'd1, 32'h3FC00000, 1'b0, 1'b0);
    req_valid[1] = 1'b1;
    wait_xfer(g);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    set_op(1, 32'h3F800000, 32'h3E800000);
    push_exp(2'd1, 32'h3FA00000, 1'b0, 1'b0);
    req_valid[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check("stall_rsp_data", 64'({rsp_id, rsp_sum, rsp_cout, rsp_of}),
            64'({2'd1, 32'h3FC00000, 1'b0, 1'b0}));
      check("stall_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_xfer(g);
    req_valid[1] = 1'b0;
    check("post_stall_grant", 64'(g), 64'd1);
    wait_drain();

    // Reset while the operation is in CALC: no response may appear
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b0011;
    wait_xfer(g);
    check("abort_grant", 64'(g), 64'd0);
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd0);
    check("abort_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    check("abort_state", 64'(dut.state), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_rsp", 64'(rsp_valid), 64'd0);

    // Two completed ops, the second flagging of
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h7F800000, 32'h3F800000);
    push_exp(2'd0, 32'h40400000, 1'b0, 1'b0);
    push_exp(2'd1, 32'h00000000, 1'b0, 1'b1);
    req_valid = 4'b0011;
    wait_xfer(g);
    req_valid[g] = 1'b0;
    wait_xfer(g);
    req_valid[g] = 1'b0;
    wait_drain();
`ifdef FPA_CTRL_STATS_EN
    check("stat_ops", 64'(stat_ops), 64'd2);
    check("stat_of", 64'(stat_of), 64'd1);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
